// File: rtl/bp_pkg.sv
// Shared branch-predictor types: update payload, scheduler state, table geometry defaults.
package bp_pkg;

  localparam int unsigned BP_ENTRIES_DEF = 1024;
  localparam int unsigned BP_PC_W_DEF    = 64;

  // One branch-resolution update as stored in the scheduler FIFO.
  typedef struct packed {
    logic [BP_PC_W_DEF-1:0] pc;
    logic                   taken;
  } bp_upd_t;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } sched_state_e;

endpackage

// File: rtl/bp_update_sched_if.sv
// Update bus between requesters, the scheduler and the predictor update port.
// slave: the scheduler's view. master: the environment (requesters + predictor).
interface bp_update_sched_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned PC_W    = 64
);

  logic [NUM_SRC-1:0]      src_valid_i;
  logic [NUM_SRC*PC_W-1:0] src_pc_i;
  logic [NUM_SRC-1:0]      src_taken_i;
  logic [NUM_SRC-1:0]      src_ready_o;

  logic                    upd_valid_o;
  logic [PC_W-1:0]         upd_pc_o;
  logic                    upd_taken_o;
  logic                    upd_ready_i;

  modport slave (
    input  src_valid_i, src_pc_i, src_taken_i, upd_ready_i,
    output src_ready_o, upd_valid_o, upd_pc_o, upd_taken_o
  );

  modport master (
    output src_valid_i, src_pc_i, src_taken_i, upd_ready_i,
    input  src_ready_o, upd_valid_o, upd_pc_o, upd_taken_o
  );

endinterface

// File: rtl/bp_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; pointer moves past the winner only when the grant is consumed.
module bp_rr_arb #(
  parameter int unsigned NUM_SRC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic               advance,
  output logic [NUM_SRC-1:0] gnt_c
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] gnt_idx;
  logic             found;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return IDX_W'(s);
  endfunction

  // Scan requesters starting at the pointer, first hit wins.
  always_comb begin
    gnt_c   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!found && req[wrap_add(ptr_q, k)]) begin
        found                      = 1'b1;
        gnt_idx                    = wrap_add(ptr_q, k);
        gnt_c[wrap_add(ptr_q, k)]  = 1'b1;
      end
    end
  end

  // Next pointer is one past the consumed grant.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bp_update_sched.sv
// Branch-predictor update scheduler: round-robin intake from NUM_SRC
// requesters into a DEPTH-entry FIFO, single-port issue to the predictor,
// and a full-table init sweep after reset or on request.
// Optional: define BP_SCHED_STATS_EN for issued/stall counters.
module bp_update_sched
  import bp_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ENTRIES = BP_ENTRIES_DEF,
  parameter int unsigned PC_W    = BP_PC_W_DEF   // must not exceed BP_PC_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  bp_update_sched_if.slave           bus,
  input  logic                       sweep_req_i,
  output logic                       sweep_valid_o,
  output logic [$clog2(ENTRIES)-1:0] sweep_idx_o,
  output logic                       sweep_busy_o,
  output logic [$clog2(DEPTH):0]     fifo_count_o
`ifdef BP_SCHED_STATS_EN
  ,
  output logic [31:0]                stat_issued_o,
  output logic [31:0]                stat_stall_o
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             fifo_clr;

  bp_upd_t          mem [DEPTH];
  bp_upd_t          head;
  bp_upd_t          push_data;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             full, empty;
  logic             push, pop;

  logic [NUM_SRC-1:0] gnt_c;
  logic [PC_W-1:0]    sel_pc;
  logic               sel_taken;

  bp_rr_arb #(.NUM_SRC(NUM_SRC)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.src_valid_i),
    .advance (push),
    .gnt_c   (gnt_c)
  );

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

  // Grant is suppressed when full, when a sweep is being requested, and during reset.
  assign bus.src_ready_o = (!rst && !full && !sweep_req_i) ? gnt_c : '0;
  assign push            = |bus.src_ready_o;

  assign head            = mem[rd_ptr];
  assign bus.upd_valid_o = (state_q == RUN) && !empty;
  assign bus.upd_pc_o    = PC_W'(head.pc);
  assign bus.upd_taken_o = head.taken;
  assign pop             = bus.upd_valid_o && bus.upd_ready_i;

  assign sweep_valid_o = (state_q == SWEEP);
  assign sweep_busy_o  = (state_q == SWEEP);
  assign sweep_idx_o   = idx_q;
  assign fifo_count_o  = cnt_q;

  // Mux the granted source's payload onto the FIFO write port.
  always_comb begin
    sel_pc    = '0;
    sel_taken = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (gnt_c[s]) begin
        sel_pc    = sel_pc | bus.src_pc_i[s*PC_W +: PC_W];
        sel_taken = sel_taken | bus.src_taken_i[s];
      end
    end
    push_data       = '0;
    push_data.pc    = BP_PC_W_DEF'(sel_pc);
    push_data.taken = sel_taken;
  end

  // Sweep/run sequencing; a sweep request in RUN also flushes the FIFO.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fifo_clr = 1'b0;
    case (state_q)
      SWEEP: begin
        if (idx_q == IDX_W'(ENTRIES - 1)) begin
          idx_d   = '0;
          state_d = RUN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      RUN: begin
        if (sweep_req_i) begin
          state_d  = SWEEP;
          idx_d    = '0;
          fifo_clr = 1'b1;
        end
      end
    endcase
  end

  // State and sweep index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SWEEP;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FIFO pointers and occupancy; a flush drops any same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst || fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage, no reset needed: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

`ifdef BP_SCHED_STATS_EN
  // Saturating issue and stall counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_o <= '0;
      stat_stall_o  <= '0;
    end else begin
      if (pop && (stat_issued_o != 32'hFFFF_FFFF))
        stat_issued_o <= stat_issued_o + 32'd1;
      if (bus.upd_valid_o && !bus.upd_ready_i && (stat_stall_o != 32'hFFFF_FFFF))
        stat_stall_o <= stat_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_update_sched.sv
// Self-checking bench for bp_update_sched: directed vectors plus randomized
// traffic against a queue-based reference model.
module tb_bp_update_sched;

  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned ENTRIES = 1024;
  localparam int unsigned PC_W    = 64;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sweep_req;
  logic       sweep_valid;
  logic [9:0] sweep_idx;
  logic       sweep_busy;
  logic [3:0] fifo_count;
`ifdef BP_SCHED_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  logic [1:0]  sv, tk;
  logic [63:0] pc0, pc1;
  logic        ur;

  bp_update_sched_if #(.NUM_SRC(NUM_SRC), .PC_W(PC_W)) bus ();

  assign bus.src_valid_i = sv;
  assign bus.src_pc_i    = {pc1, pc0};
  assign bus.src_taken_i = tk;
  assign bus.upd_ready_i = ur;

  bp_update_sched #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .ENTRIES(ENTRIES), .PC_W(PC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .sweep_req_i   (sweep_req),
    .sweep_valid_o (sweep_valid),
    .sweep_idx_o   (sweep_idx),
    .sweep_busy_o  (sweep_busy),
    .fifo_count_o  (fifo_count)
`ifdef BP_SCHED_STATS_EN
    ,
    .stat_issued_o (stat_issued),
    .stat_stall_o  (stat_stall)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a sweep flag/counter, an RR pointer and a queue.
  typedef struct {
    logic [63:0] pc;
    logic        taken;
  } mrec_t;

  bit          m_sweep = 1'b1;
  int          m_idx   = 0;
  int          m_rr    = 0;
  mrec_t       m_q[$];
  logic [63:0] pops[$];

  typedef struct {
    logic [1:0]  sv;
    logic        ur;
    logic [1:0]  e_rdy;
    logic        e_vld;
    logic [63:0] e_pc;
    logic [3:0]  e_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_grant();
    if (m_q.size() >= int'(DEPTH) || sweep_req || sv == 2'b00) return -1;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      int s;
      s = (m_rr + k) % int'(NUM_SRC);
      if (sv[s]) return s;
    end
    return -1;
  endfunction

  task automatic compare_model();
    int         g;
    logic [1:0] e;
    logic       ev;
    if (rst) return;
    g = m_grant();
    e = 2'b00;
    if (g >= 0) e[g] = 1'b1;
    ev = !m_sweep && (m_q.size() != 0);
    chk("src_ready", 64'(bus.src_ready_o), 64'(e));
    chk("upd_valid", 64'(bus.upd_valid_o), 64'(ev));
    if (ev) begin
      chk("upd_pc", bus.upd_pc_o, m_q[0].pc);
      chk("upd_taken", 64'(bus.upd_taken_o), 64'(m_q[0].taken));
    end
    chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
    chk("sweep_valid", 64'(sweep_valid), 64'(m_sweep));
    chk("sweep_busy", 64'(sweep_busy), 64'(m_sweep));
    chk("sweep_idx", 64'(sweep_idx), 64'(m_idx));
    if (bus.upd_valid_o && ur) pops.push_back(bus.upd_pc_o);
  endtask

  task automatic model_update();
    int g;
    bit p;
    if (rst) begin
      m_sweep = 1'b1; m_idx = 0; m_rr = 0; m_q.delete();
      return;
    end
    g = m_grant();
    p = !m_sweep && (m_q.size() != 0) && ur;
    if (!m_sweep && sweep_req) begin
      m_q.delete(); m_sweep = 1'b1; m_idx = 0;
      return;
    end
    if (p) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back('{pc: (g == 0) ? pc0 : pc1, taken: tk[g]});
      m_rr = (g + 1) % int'(NUM_SRC);
    end
    if (m_sweep) begin
      if (m_idx == int'(ENTRIES) - 1) begin m_sweep = 1'b0; m_idx = 0; end
      else m_idx++;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    compare_model();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    vec_t tbl[6];
    int   nsw, nupd, k;
    bit   hit;

    rst = 1'b1; sv = '0; tk = '0; pc0 = '0; pc1 = '0; ur = 1'b0; sweep_req = 1'b0;
    at_pos(); at_pos();
    rst = 1'b0;

    // Reset state and the post-reset sweep.
    nsw = 0; nupd = 0;
    for (int i = 0; i < 1030; i++) begin
      at_neg();
      if (i == 0) begin
        chk("rst_sweep_valid", 64'(sweep_valid), 64'd1);
        chk("rst_sweep_busy", 64'(sweep_busy), 64'd1);
        chk("rst_sweep_idx", 64'(sweep_idx), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("rst_upd_valid", 64'(bus.upd_valid_o), 64'd0);
        chk("rst_src_ready", 64'(bus.src_ready_o), 64'd0);
      end
      if (sweep_valid) nsw++;
      if (bus.upd_valid_o) nupd++;
      if (i == 500)  chk("sweep_idx_500", 64'(sweep_idx), 64'd500);
      if (i == 1023) chk("sweep_idx_last", 64'(sweep_idx), 64'd1023);
      if (i == 1024) chk("sweep_done_busy", 64'(sweep_busy), 64'd0);
      at_pos();
    end
    chk("sweep_cycles", 64'(nsw), 64'd1024);
    chk("sweep_no_upd", 64'(nupd), 64'd0);

    // Round-robin alternation and one-cycle issue latency.
    tbl[0] = '{2'b11, 1'b1, 2'b01, 1'b0, 64'h0,   4'd0};
    tbl[1] = '{2'b11, 1'b1, 2'b10, 1'b1, 64'h100, 4'd1};
    tbl[2] = '{2'b11, 1'b1, 2'b01, 1'b1, 64'h200, 4'd1};
    tbl[3] = '{2'b11, 1'b1, 2'b10, 1'b1, 64'h100, 4'd1};
    tbl[4] = '{2'b00, 1'b1, 2'b00, 1'b1, 64'h200, 4'd1};
    tbl[5] = '{2'b00, 1'b1, 2'b00, 1'b0, 64'h0,   4'd0};
    pc0 = 64'h100; pc1 = 64'h200; tk = 2'b01;
    for (int i = 0; i < 6; i++) begin
      sv = tbl[i].sv; ur = tbl[i].ur;
      at_neg();
      chk($sformatf("rr%0d_ready", i), 64'(bus.src_ready_o), 64'(tbl[i].e_rdy));
      chk($sformatf("rr%0d_valid", i), 64'(bus.upd_valid_o), 64'(tbl[i].e_vld));
      if (tbl[i].e_vld) chk($sformatf("rr%0d_pc", i), bus.upd_pc_o, tbl[i].e_pc);
      chk($sformatf("rr%0d_count", i), 64'(fifo_count), 64'(tbl[i].e_cnt));
      at_pos();
    end

    // Fill to full with the predictor stalled, then drain in order.
    ur = 1'b0; sv = 2'b01; k = 0; pc0 = 64'h1000;
    for (int i = 0; i < 20 && k < 8; i++) begin
      logic acc;
      at_neg();
      acc = bus.src_ready_o[0];
      at_pos();
      if (acc) begin k++; pc0 = 64'h1000 + 64'(k); end
    end
    chk("fill_accepts", 64'(k), 64'd8);
    at_neg();
    chk("full_count", 64'(fifo_count), 64'd8);
    chk("full_ready", 64'(bus.src_ready_o), 64'd0);
    at_pos();
    pops.delete(); ur = 1'b1;
    at_neg();
    chk("full_pop_ready", 64'(bus.src_ready_o), 64'd0);
    chk("full_pop_valid", 64'(bus.upd_valid_o), 64'd1);
    at_pos();
    at_neg();
    chk("after_pop_ready", 64'(bus.src_ready_o), 64'b01);
    chk("after_pop_count", 64'(fifo_count), 64'd7);
    at_pos();
    sv = 2'b00;
    for (int i = 0; i < 20; i++) begin at_neg(); at_pos(); end
    chk("drain_count", 64'(pops.size()), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < pops.size()) chk($sformatf("drain_pc%0d", i), pops[i], 64'h1000 + 64'(i));
    end

    // Sweep request flushes a partly full FIFO; sweep-time updates issue afterwards.
    ur = 1'b0; sv = 2'b01; pc0 = 64'h2000;
    for (int i = 0; i < 3; i++) begin at_neg(); at_pos(); pc0 = pc0 + 64'd1; end
    sv = 2'b00; sweep_req = 1'b1;
    at_neg();
    chk("pre_sweep_count", 64'(fifo_count), 64'd3);
    at_pos();
    sweep_req = 1'b0;
    at_neg();
    chk("req_sweep_busy", 64'(sweep_busy), 64'd1);
    chk("req_sweep_count", 64'(fifo_count), 64'd0);
    chk("req_sweep_valid", 64'(bus.upd_valid_o), 64'd0);
    chk("req_sweep_idx", 64'(sweep_idx), 64'd0);
    at_pos();
    sv = 2'b10; pc1 = 64'hA0; ur = 1'b1;
    at_neg(); chk("sweep_enq0_ready", 64'(bus.src_ready_o), 64'b10); at_pos();
    pc1 = 64'hA1;
    at_neg(); chk("sweep_enq1_ready", 64'(bus.src_ready_o), 64'b10); at_pos();
    sv = 2'b00;
    hit = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      at_neg();
      if (!sweep_busy) begin hit = 1'b1; break; end
      at_pos();
    end
    chk("sweep_end_seen", 64'(hit), 64'd1);
    chk("post_sweep_valid", 64'(bus.upd_valid_o), 64'd1);
    chk("post_sweep_pc", bus.upd_pc_o, 64'hA0);
    at_pos();
    for (int i = 0; i < 4; i++) begin at_neg(); at_pos(); end

    // Reset in the middle of a sweep.
    sweep_req = 1'b1;
    at_neg(); at_pos();
    sweep_req = 1'b0; sv = 2'b01; pc0 = 64'h3000;
    hit = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      at_neg();
      if (sweep_idx == 10'd500) begin hit = 1'b1; break; end
      at_pos();
    end
    chk("mid_sweep_reached", 64'(hit), 64'd1);
    rst = 1'b1;
    at_pos();
    rst = 1'b0; sv = 2'b00;
    at_neg();
    chk("midrst_idx", 64'(sweep_idx), 64'd0);
    chk("midrst_count", 64'(fifo_count), 64'd0);
    chk("midrst_busy", 64'(sweep_busy), 64'd1);
    at_pos();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      sv        = 2'($urandom);
      tk        = 2'($urandom);
      pc0       = {$urandom, $urandom};
      pc1       = {$urandom, $urandom};
      ur        = ($urandom_range(0, 3) != 0);
      sweep_req = ($urandom_range(0, 299) == 0);
      rst       = ($urandom_range(0, 2499) == 0);
      at_neg();
      at_pos();
    end
    rst = 1'b0; sweep_req = 1'b0; sv = 2'b00;

`ifdef BP_SCHED_STATS_EN
    // Five stall cycles followed by three issues.
    rst = 1'b1;
    at_pos();
    rst = 1'b0; ur = 1'b0; sv = 2'b01; pc0 = 64'h4000;
    for (int i = 0; i < 3; i++) begin at_neg(); at_pos(); pc0 = pc0 + 64'd1; end
    sv = 2'b00;
    hit = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      at_neg();
      if (!sweep_busy) begin hit = 1'b1; break; end
      at_pos();
    end
    chk("stats_sweep_end", 64'(hit), 64'd1);
    at_pos();
    for (int i = 0; i < 4; i++) begin at_neg(); at_pos(); end
    ur = 1'b1;
    for (int i = 0; i < 3; i++) begin at_neg(); at_pos(); end
    ur = 1'b0;
    at_neg();
    chk("stat_stall", 64'(stat_stall), 64'd5);
    chk("stat_issued", 64'(stat_issued), 64'd3);
    at_pos();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
